// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: decoded ID bundle in, per-stage control and hazard selects out.
interface ctrl_pipeline_if;
  logic [7:0] Control_i;
  logic       Jump_i;
  logic       Branch_i;
  logic       Eq_i;
  logic [4:0] RsAddr_i;
  logic [4:0] RtAddr_i;
  logic [4:0] RdAddr_i;
  logic       EX_ALUSrc_o;
  logic [1:0] EX_ALUOp_o;
  logic       EX_RegDst_o;
  logic       MEM_MemRead_o;
  logic       MEM_MemWrite_o;
  logic       WB_RegWrite_o;
  logic       WB_MemtoReg_o;
  logic [4:0] WB_WriteAddr_o;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFFlush_o;
  logic [1:0] ForwardA_o;
  logic [1:0] ForwardB_o;

  // Decoder / datapath side
  modport master (
    output Control_i, Jump_i, Branch_i, Eq_i, RsAddr_i, RtAddr_i, RdAddr_i,
    input  EX_ALUSrc_o, EX_ALUOp_o, EX_RegDst_o, MEM_MemRead_o, MEM_MemWrite_o,
    input  WB_RegWrite_o, WB_MemtoReg_o, WB_WriteAddr_o,
    input  PCWrite_o, IFIDWrite_o, IFFlush_o, ForwardA_o, ForwardB_o
  );

  // Control pipeline side
  modport slave (
    input  Control_i, Jump_i, Branch_i, Eq_i, RsAddr_i, RtAddr_i, RdAddr_i,
    output EX_ALUSrc_o, EX_ALUOp_o, EX_RegDst_o, MEM_MemRead_o, MEM_MemWrite_o,
    output WB_RegWrite_o, WB_MemtoReg_o, WB_WriteAddr_o,
    output PCWrite_o, IFIDWrite_o, IFFlush_o, ForwardA_o, ForwardB_o
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// Control word carrier ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// IF flush on taken branch / jump, and EX operand forwarding selects.
// Control word layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}.
module ctrl_pipeline (
  input  logic           clk_i,
  input  logic           rst_i,
  ctrl_pipeline_if.slave bus
);

  typedef struct packed {
    logic [7:0] ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] waddr;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] waddr;
  } memwb_t;

  idex_t  ex_q, ex_d;
  exmem_t mem_q, mem_d;
  memwb_t wb_q, wb_d;

  logic       stall;
  logic [4:0] ex_waddr;

  // EX/MEM has priority over MEM/WB; register $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input exmem_t m, input memwb_t w);
    if (m.reg_write && (m.waddr != 5'd0) && (m.waddr == src))      fwd_sel = 2'b10;
    else if (w.reg_write && (w.waddr != 5'd0) && (w.waddr == src)) fwd_sel = 2'b01;
    else                                                            fwd_sel = 2'b00;
  endfunction

  // Hazard detection and next-state for each stage register.
  // The load-use compare ignores instruction type on purpose: a spurious stall is harmless.
  always_comb begin
    stall    = ex_q.ctrl[5] && (ex_q.rt != 5'd0) &&
               ((ex_q.rt == bus.RsAddr_i) || (ex_q.rt == bus.RtAddr_i));
    ex_waddr = ex_q.ctrl[0] ? ex_q.rd : ex_q.rt;

    // Bubble zeroes only the control; register fields still track ID.
    ex_d.ctrl = stall ? 8'd0 : bus.Control_i;
    ex_d.rs   = bus.RsAddr_i;
    ex_d.rt   = bus.RtAddr_i;
    ex_d.rd   = bus.RdAddr_i;

    mem_d.reg_write  = ex_q.ctrl[7];
    mem_d.mem_to_reg = ex_q.ctrl[6];
    mem_d.mem_read   = ex_q.ctrl[5];
    mem_d.mem_write  = ex_q.ctrl[4];
    mem_d.waddr      = ex_waddr;

    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.waddr      = mem_q.waddr;
  end

  // Stage registers; reset discards all in-flight control at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.EX_ALUSrc_o    = ex_q.ctrl[3];
  assign bus.EX_ALUOp_o     = ex_q.ctrl[2:1];
  assign bus.EX_RegDst_o    = ex_q.ctrl[0];
  assign bus.MEM_MemRead_o  = mem_q.mem_read;
  assign bus.MEM_MemWrite_o = mem_q.mem_write;
  assign bus.WB_RegWrite_o  = wb_q.reg_write;
  assign bus.WB_MemtoReg_o  = wb_q.mem_to_reg;
  assign bus.WB_WriteAddr_o = wb_q.waddr;

  // A stalled branch must not flush yet: the instruction behind it stays put.
  assign bus.PCWrite_o   = ~stall;
  assign bus.IFIDWrite_o = ~stall;
  assign bus.IFFlush_o   = (bus.Jump_i | (bus.Branch_i & bus.Eq_i)) & ~stall;
  assign bus.ForwardA_o  = fwd_sel(ex_q.rs, mem_q, wb_q);
  assign bus.ForwardB_o  = fwd_sel(ex_q.rt, mem_q, wb_q);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: issue-history model checked every cycle plus directed literals.
module tb_ctrl_pipeline;

  logic clk;
  logic rst_i;
  ctrl_pipeline_if bus();

  ctrl_pipeline dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: h[0] is what entered EX most recently, h[1] one cycle earlier, h[2] two earlier.
  typedef struct {
    logic [7:0] c;
    logic [4:0] rs, rt, rd;
  } ent_t;

  ent_t h[3];

  function automatic ent_t zero_ent();
    ent_t e;
    e.c = 8'd0; e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0;
    return e;
  endfunction

  function automatic logic [4:0] dest(input ent_t e);
    return e.c[0] ? e.rd : e.rt;
  endfunction

  function automatic bit m_stall();
    return h[0].c[5] && h[0].rt != 0 && (h[0].rt == bus.RsAddr_i || h[0].rt == bus.RtAddr_i);
  endfunction

  function automatic int m_fwd(input logic [4:0] src);
    if (h[1].c[7] && dest(h[1]) != 0 && dest(h[1]) == src) return 2;
    if (h[2].c[7] && dest(h[2]) != 0 && dest(h[2]) == src) return 1;
    return 0;
  endfunction

  // Model update: record what ID hands to EX on every edge.
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      h[0] = zero_ent(); h[1] = zero_ent(); h[2] = zero_ent();
    end else begin
      ent_t e;
      e.c  = m_stall() ? 8'd0 : bus.Control_i;
      e.rs = bus.RsAddr_i; e.rt = bus.RtAddr_i; e.rd = bus.RdAddr_i;
      h[2] = h[1]; h[1] = h[0]; h[0] = e;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_i) begin
      chk("EX_ALUSrc",    bus.EX_ALUSrc_o,    h[0].c[3]);
      chk("EX_ALUOp",     bus.EX_ALUOp_o,     h[0].c[2:1]);
      chk("EX_RegDst",    bus.EX_RegDst_o,    h[0].c[0]);
      chk("MEM_MemRead",  bus.MEM_MemRead_o,  h[1].c[5]);
      chk("MEM_MemWrite", bus.MEM_MemWrite_o, h[1].c[4]);
      chk("WB_RegWrite",  bus.WB_RegWrite_o,  h[2].c[7]);
      chk("WB_MemtoReg",  bus.WB_MemtoReg_o,  h[2].c[6]);
      chk("WB_WriteAddr", bus.WB_WriteAddr_o, dest(h[2]));
      chk("PCWrite",      bus.PCWrite_o,      !m_stall());
      chk("IFIDWrite",    bus.IFIDWrite_o,    !m_stall());
      chk("IFFlush",      bus.IFFlush_o,      (bus.Jump_i || (bus.Branch_i && bus.Eq_i)) && !m_stall());
      chk("ForwardA",     bus.ForwardA_o,     m_fwd(h[0].rs));
      chk("ForwardB",     bus.ForwardB_o,     m_fwd(h[0].rt));
    end
  end

  // One ID cycle: drive just after the edge, return at the following negedge.
  task automatic issue(input logic [7:0] c, input logic j, input logic b, input logic eq,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    @(posedge clk); #1;
    bus.Control_i = c; bus.Jump_i = j; bus.Branch_i = b; bus.Eq_i = eq;
    bus.RsAddr_i = rs; bus.RtAddr_i = rt; bus.RdAddr_i = rd;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(8'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_ALUSrc"},   bus.EX_ALUSrc_o,    0);
    chk({tag, "_ALUOp"},    bus.EX_ALUOp_o,     0);
    chk({tag, "_RegDst"},   bus.EX_RegDst_o,    0);
    chk({tag, "_MemRead"},  bus.MEM_MemRead_o,  0);
    chk({tag, "_MemWrite"}, bus.MEM_MemWrite_o, 0);
    chk({tag, "_RegWrite"}, bus.WB_RegWrite_o,  0);
    chk({tag, "_MemtoReg"}, bus.WB_MemtoReg_o,  0);
    chk({tag, "_WAddr"},    bus.WB_WriteAddr_o, 0);
  endtask

  localparam logic [7:0] RTYPE = 8'b10000111;
  localparam logic [7:0] LW    = 8'b11101000;
  localparam logic [7:0] SW    = 8'b00011000;

  initial begin
    h[0] = zero_ent(); h[1] = zero_ent(); h[2] = zero_ent();
    rst_i = 1'b1;
    bus.Control_i = 8'd0; bus.Jump_i = 0; bus.Branch_i = 0; bus.Eq_i = 0;
    bus.RsAddr_i = 5'd0; bus.RtAddr_i = 5'd0; bus.RdAddr_i = 5'd0;
    #1 rst_i = 1'b0;
    #2;
    chk_regs_zero("rst");
    chk("rst_PCWrite",   bus.PCWrite_o,   1);
    chk("rst_IFIDWrite", bus.IFIDWrite_o, 1);
    chk("rst_IFFlush",   bus.IFFlush_o,   0);
    chk("rst_FwdA",      bus.ForwardA_o,  0);
    chk("rst_FwdB",      bus.ForwardB_o,  0);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    cmp_en = 1;

    // R-type flow, rd=5
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd2, 5'd5);
    nop();
    chk("rt_ALUOp",  bus.EX_ALUOp_o,  3);
    chk("rt_RegDst", bus.EX_RegDst_o, 1);
    nop();
    nop();
    chk("rt_WB_RegWrite", bus.WB_RegWrite_o,  1);
    chk("rt_WB_WAddr",    bus.WB_WriteAddr_o, 5);

    // Load-use: lw $8 then add rs=8
    issue(LW, 0, 0, 0, 5'd1, 5'd8, 5'd0);
    issue(RTYPE, 0, 0, 0, 5'd8, 5'd9, 5'd10);
    chk("lu_PCWrite",   bus.PCWrite_o,   0);
    chk("lu_IFIDWrite", bus.IFIDWrite_o, 0);
    issue(RTYPE, 0, 0, 0, 5'd8, 5'd9, 5'd10);
    chk("lu_bubble_ALUOp",  bus.EX_ALUOp_o,  0);
    chk("lu_bubble_RegDst", bus.EX_RegDst_o, 0);
    chk("lu_PCWrite_after", bus.PCWrite_o,   1);
    nop();
    chk("lu_FwdA",       bus.ForwardA_o,     1);
    chk("lu_WB_WAddr",   bus.WB_WriteAddr_o, 8);
    chk("lu_WB_MemtoReg", bus.WB_MemtoReg_o, 1);

    // Forward priority on $3
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    issue(RTYPE, 0, 0, 0, 5'd3, 5'd6, 5'd4);
    nop();
    chk("fp_FwdA_10", bus.ForwardA_o, 2);
    chk("fp_FwdB_00", bus.ForwardB_o, 0);
    issue(RTYPE, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    issue(RTYPE, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    issue(RTYPE, 0, 0, 0, 5'd0, 5'd0, 5'd7);
    nop();
    chk("fp_zero_FwdA", bus.ForwardA_o, 0);
    chk("fp_zero_FwdB", bus.ForwardB_o, 0);

    // MEM/WB-only forward on B
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd2, 5'd12);
    nop();
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd12, 5'd13);
    nop();
    chk("fw_FwdB_01", bus.ForwardB_o, 1);

    // Branch / jump
    issue(8'd0, 0, 1, 1, 5'd1, 5'd2, 5'd0);
    chk("br_taken", bus.IFFlush_o, 1);
    issue(8'd0, 0, 1, 0, 5'd1, 5'd2, 5'd0);
    chk("br_nottaken", bus.IFFlush_o, 0);
    issue(8'd0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("jump", bus.IFFlush_o, 1);

    // Jump behind a load-use stall
    issue(LW, 0, 0, 0, 5'd1, 5'd7, 5'd0);
    issue(8'd0, 1, 0, 0, 5'd7, 5'd0, 5'd0);
    chk("js_flush_stall", bus.IFFlush_o, 0);
    chk("js_pc_stall",    bus.PCWrite_o, 0);
    issue(8'd0, 1, 0, 0, 5'd7, 5'd0, 5'd0);
    chk("js_flush_after", bus.IFFlush_o, 1);
    chk("js_pc_after",    bus.PCWrite_o, 1);

    // Back-to-back dependent loads: one stall each
    issue(LW, 0, 0, 0, 5'd1, 5'd8, 5'd0);
    issue(LW, 0, 0, 0, 5'd8, 5'd9, 5'd0);
    chk("bb_stall1", bus.PCWrite_o, 0);
    issue(LW, 0, 0, 0, 5'd8, 5'd9, 5'd0);
    chk("bb_go1", bus.PCWrite_o, 1);
    issue(RTYPE, 0, 0, 0, 5'd9, 5'd2, 5'd11);
    chk("bb_stall2", bus.PCWrite_o, 0);
    issue(RTYPE, 0, 0, 0, 5'd9, 5'd2, 5'd11);
    chk("bb_go2", bus.PCWrite_o, 1);
    nop();

    // sw path
    issue(SW, 0, 0, 0, 5'd1, 5'd2, 5'd0);
    nop();
    nop();
    chk("sw_MemWrite", bus.MEM_MemWrite_o, 1);
    chk("sw_MemRead",  bus.MEM_MemRead_o,  0);
    nop();
    chk("sw_WB_RegWrite", bus.WB_RegWrite_o, 0);

    // Reset mid-stream while a store strobe is up
    issue(SW, 0, 0, 0, 5'd1, 5'd2, 5'd0);
    issue(LW, 0, 0, 0, 5'd3, 5'd4, 5'd0);
    nop();
    chk("mr_MemWrite_pre", bus.MEM_MemWrite_o, 1);
    rst_i = 1'b0;
    #1;
    chk_regs_zero("mr");
    chk("mr_PCWrite", bus.PCWrite_o, 1);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    issue(RTYPE, 0, 0, 0, 5'd1, 5'd2, 5'd14);
    nop();
    chk("post_rst_RegDst", bus.EX_RegDst_o, 1);
    nop();
    nop();
    chk("post_rst_WAddr", bus.WB_WriteAddr_o, 14);
    nop();

    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined carrier for the 8-bit control word produced by the instruction decoder. Accepts the decoded bundle in ID and registers it through ID/EX, EX/MEM and MEM/WB. Each downstream stage reads only its own fields. Also owns the pipeline's hazard logic:
- load-use stall,
- IF flush on taken branch/jump,
- EX operand forwarding select.

## Interface
Parameters: none; all widths are fixed by the ISA.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- Control_i  in  8  decoded ID control word {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}, bit 7 down to bit 0
- Jump_i  in  1  ID instruction is j
- Branch_i  in  1  ID instruction is beq
- Eq_i  in  1  ID register-file operands are equal
- RsAddr_i  in  5  ID rs field
- RtAddr_i  in  5  ID rt field
- RdAddr_i  in  5  ID rd field
- EX_ALUSrc_o  out  1  ALU B source select in EX
- EX_ALUOp_o  out  2  ALUOp in EX
- EX_RegDst_o  out  1  RegDst in EX
- MEM_MemRead_o  out  1  data memory read
- MEM_MemWrite_o  out  1  data memory write
- WB_RegWrite_o  out  1  register file write enable
- WB_MemtoReg_o  out  1  writeback source select
- WB_WriteAddr_o  out  5  register file write address
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register enable
- IFFlush_o  out  1  zero the IF/ID instruction
- ForwardA_o  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- ForwardB_o  out  2  EX operand B select, same encoding as ForwardA_o

## Operation
Stage registers:
- ID/EX holds the full 8-bit word plus rs, rt and rd.
- EX/MEM holds {RegWrite, MemtoReg, MemRead, MemWrite} plus the write address.
- MEM/WB holds {RegWrite, MemtoReg} plus the write address.

Write address:
- Computed in EX as RegDst ? rd : rt.
- Registered into EX/MEM, then into MEM/WB.

Load-use stall is combinational:
- stall = ex_MemRead & (ex_rt != 0) & (ex_rt == RsAddr_i | ex_rt == RtAddr_i).
- The compare is not qualified by instruction type, so it is conservative for sw, beq and addi.

During stall:
- PCWrite_o = 0 and IFIDWrite_o = 0.
- ID/EX loads all-zero control (bubble). Its rs, rt and rd fields still load.
- EX/MEM and MEM/WB advance normally.

Flush:
- IFFlush_o = (Jump_i | (Branch_i & Eq_i)) & ~stall.
- Stall has priority: a branch waiting on a load does not flush until the stall clears.
- Control_i is loaded into ID/EX unchanged. The decoder already emits no write or memory bits for beq and j.

Forwarding, evaluated identically for A (ex_rs) and B (ex_rt):
- 10 when mem_RegWrite & (mem_waddr != 0) & (mem_waddr == ex_rs/ex_rt).
- Else 01 when wb_RegWrite & (wb_waddr != 0) & (wb_waddr == ex_rs/ex_rt).
- Else 00.
- EX/MEM wins over MEM/WB when both match.

## Timing
- Reset (rst_i low, asynchronous): every stage register clears to 0. All registered outputs read 0 and WB_WriteAddr_o = 0.
- Combinational outputs read at reset:
  - PCWrite_o = 1, IFIDWrite_o = 1, IFFlush_o = 0, ForwardA_o = ForwardB_o = 00.
  - This holds provided Jump_i = Branch_i = 0.
- Reset release: the first rising edge after rst_i goes high loads Control_i.
- Reset mid-operation: all in-flight control is discarded immediately, with no partial writeback or memory strobe.

Latency of a control word:
- EX fields visible 1 cycle after ID.
- MEM fields visible after 2 cycles.
- WB fields visible after 3 cycles.

Stall duration:
- A load-use stall lasts exactly 1 cycle. The bubble clears ex_MemRead, so the stall self-terminates.
- Back-to-back loads with a dependency stall once each.

Flush:
- IFFlush_o is combinational in the cycle the jump or taken beq sits in ID.
- Exactly one fetched instruction is discarded.

All hazard and forward outputs are purely combinational from current stage state and ID inputs. They have no registered delay.

## Test plan
- Reset: rst_i=0 mid-stream with MEM_MemWrite_o=1 -> all registered outputs 0 immediately; PCWrite_o=1.
- R-type flow: Control_i=8'b10000111, rd=5 -> EX_ALUOp_o=11 and EX_RegDst_o=1 at cycle+1; WB_RegWrite_o=1 and WB_WriteAddr_o=5 at cycle+3.
- Load-use stall:
  - Stimulus: lw rt=8 (8'b11101000) followed by add with rs=8.
  - Stall cycle: PCWrite_o=0, IFIDWrite_o=0; the next EX word is 0.
  - Following cycle: PCWrite_o=1. The add reaches EX with ForwardA_o=01 while the lw is in WB.
- Forward priority: writes to $3 in both EX/MEM and MEM/WB, EX rs=3 -> ForwardA_o=10. With writes to $0 only -> 00.
- Branch/jump:
  - Branch_i=1, Eq_i=1 -> IFFlush_o=1.
  - Branch_i=1, Eq_i=0 -> 0.
  - Jump_i=1 together with a load-use stall -> IFFlush_o=0 for the stall cycle, then 1.
- sw path: Control_i=8'b00011000 -> MEM_MemWrite_o=1 at cycle+2; WB_RegWrite_o=0 at cycle+3.
